vz_upload: RTL and testbench

- Core-side reader for the HPS file-upload channel. It is the reverse of the VZ image download path.
- When the HPS starts an upload (save of a VZ image), the block latches the BASIC program bounds from the Laser310 system variables in RAM.
- It then answers byte read requests with a synthesized 24-byte VZ header followed by program bytes fetched from main RAM.
- It sits between hps_io's upload signals and a spare read port of the system RAM in LASER310_TOP.

---
 rtl/vz_pkg.sv | 54 +++++
 rtl/vz_header_rom.sv | 33 +++
 rtl/vz_upload.sv | 200 ++++++++++++++++++++
 tb/tb_vz_upload.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vz_pkg.sv
// Shared definitions for the VZ image format: header layout, file-type
// codes, upload FSM states and small helpers for the fixed header bytes.
package vz_pkg;

  // Header layout: magic, name field, type byte, little-endian start address
  localparam int VZ_HDR_LEN   = 24;
  localparam int VZ_NAME_OFS  = 4;
  localparam int VZ_NAME_LEN  = 17;
  localparam int VZ_TYPE_OFS  = 21;
  localparam int VZ_START_OFS = 22;

  // "VZF0", byte 0 in the top octet
  localparam logic [31:0] VZ_MAGIC = 32'h565A_4630;

  // Name written into every uploaded image, zero padded to VZ_NAME_LEN
  localparam int          VZ_NAME_CHARS = 6;
  localparam logic [47:0] VZ_NAME       = 48'h4D49_5354_4552;  // "MISTER"

  // File type codes
  localparam logic [7:0] VZ_BASIC = 8'hF0;
  localparam logic [7:0] VZ_BIN   = 8'hF1;

  // Upload FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_P0    = 3'd1,
    ST_P1    = 3'd2,
    ST_P2    = 3'd3,
    ST_P3    = 3'd4,
    ST_READY = 3'd5,
    ST_HDR   = 3'd6,
    ST_FETCH = 3'd7
  } vz_state_e;

  // Byte idx (0..3) of the magic string
  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = VZ_MAGIC[31:24];
      2'd1:    b = VZ_MAGIC[23:16];
      2'd2:    b = VZ_MAGIC[15:8];
      default: b = VZ_MAGIC[7:0];
    endcase
    return b;
  endfunction

  // Byte idx of the name field; characters past the name are padding
  function automatic logic [7:0] name_byte(input int idx);
    if (idx >= 0 && idx < VZ_NAME_CHARS)
      return VZ_NAME[8*(VZ_NAME_CHARS-1-idx) +: 8];
    return 8'h00;
  endfunction

endpackage

// File: rtl/vz_header_rom.sv
// Combinational VZ header generator: maps a header offset (0..23) plus the
// program start address and type code to the header byte at that offset.
// Offsets beyond the header return zero.
module vz_header_rom
  import vz_pkg::*;
(
  input  logic [4:0]  offset,
  input  logic [15:0] start,
  input  logic [7:0]  file_type,
  output logic [7:0]  data
);

  int ofs;

  // Select the header field covering the requested offset
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    data = 8'h00;
    ofs  = int'(offset);
    if (ofs < VZ_NAME_OFS)
      data = magic_byte(offset[1:0]);
    else if (ofs < VZ_NAME_OFS + VZ_NAME_LEN)
      data = name_byte(ofs - VZ_NAME_OFS);
    else if (ofs == VZ_TYPE_OFS)
      data = file_type;
    else if (ofs == VZ_START_OFS)
      data = start[7:0];
    else if (ofs == VZ_START_OFS + 1)
      data = start[15:8];
  end

endmodule

// File: rtl/vz_upload.sv
// HPS upload reader for VZ images. On the start of an upload it fetches the
// BASIC program start/end pointers from RAM, then serves byte reads with a
// synthesized 24-byte header followed by the program bytes from RAM.
module vz_upload
  import vz_pkg::*;
#(
  parameter int          MEM_LAT   = 2,         // RAM read latency, 1..4
  parameter logic [7:0]  FILE_TYPE = VZ_BASIC,
  parameter logic [15:0] PTR_START = 16'h78A4,
  parameter logic [15:0] PTR_END   = 16'h78F9
) (
  input  logic        CLK42MHZ,
  input  logic        RESET,
  input  logic        up_active,
  input  logic        up_rd,
  input  logic [15:0] up_addr,
  output logic [7:0]  up_din,
  output logic        up_wait,
  output logic [16:0] up_size,
  output logic        ready,
  output logic        overrun,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data
);

  // Counter value at which the byte requested on state entry is on mem_data
  localparam logic [2:0]  LAT_LAST = 3'(MEM_LAT);
  localparam logic [15:0] HDR_LEN  = 16'(VZ_HDR_LEN);

  vz_state_e   state;
  logic [2:0]  cnt;
  logic        active_q;
  logic [7:0]  start_lo;
  logic [7:0]  start_hi;
  logic [7:0]  end_lo;
  logic [15:0] rd_addr;

  logic [15:0] start_w;
  logic [15:0] end_w;
  logic [15:0] len;
  logic [16:0] size_next;
  logic        in_hdr;
  logic        past_end;
  logic [15:0] fetch_addr;
  logic [7:0]  hdr_byte;
  logic        lat_done;

  vz_header_rom u_hdr (
    .offset    (rd_addr[4:0]),
    .start     (start_w),
    .file_type (FILE_TYPE),
    .data      (hdr_byte)
  );

  // File length from the pointers (end high byte arrives on mem_data in P3)
  // and classification of an incoming read address
  always_comb begin
    start_w    = {start_hi, start_lo};
    end_w      = {mem_data, end_lo};
    len        = (end_w < start_w) ? 16'h0000 : (end_w - start_w);
    size_next  = {1'b0, HDR_LEN} + {1'b0, len};
    in_hdr     = (up_addr < HDR_LEN);
    past_end   = ({1'b0, up_addr} >= up_size);
    fetch_addr = start_w + (up_addr - HDR_LEN);
    lat_done   = (cnt == LAT_LAST);
  end

  // Upload FSM: pointer fetch, then header / RAM byte service
  always_ff @(posedge CLK42MHZ or negedge RESET) begin
    if (!RESET) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      active_q <= 1'b0;
      start_lo <= '0;
      start_hi <= '0;
      end_lo   <= '0;
      rd_addr  <= '0;
      up_din   <= '0;
      up_wait  <= 1'b0;
      up_size  <= '0;
      ready    <= 1'b0;
      overrun  <= 1'b0;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values of the previous clock, independent of statement order.
      active_q <= up_active;
      mem_rd   <= 1'b0;

      if (!up_active) begin
        // Upload ended or aborted: any RAM data still in flight is ignored
        state   <= ST_IDLE;
        ready   <= 1'b0;
        up_wait <= 1'b0;
      end else begin
        // A strobe while a read is outstanding is dropped and remembered;
        // strobes during the pointer fetch are silently ignored
        if (up_rd && up_wait && (state == ST_HDR || state == ST_FETCH))
          overrun <= 1'b1;

        case (state)
          ST_IDLE: begin
            if (!active_q) begin
              state    <= ST_P0;
              up_wait  <= 1'b1;
              overrun  <= 1'b0;
              cnt      <= '0;
              mem_addr <= PTR_START;
              mem_rd   <= 1'b1;
            end
          end

          ST_P0: begin
            if (lat_done) begin
              start_lo <= mem_data;
              state    <= ST_P1;
              cnt      <= '0;
              mem_addr <= PTR_START + 16'd1;
              mem_rd   <= 1'b1;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end

          ST_P1: begin
            if (lat_done) begin
              start_hi <= mem_data;
              state    <= ST_P2;
              cnt      <= '0;
              mem_addr <= PTR_END;
              mem_rd   <= 1'b1;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end

          ST_P2: begin
            if (lat_done) begin
              end_lo   <= mem_data;
              state    <= ST_P3;
              cnt      <= '0;
              mem_addr <= PTR_END + 16'd1;
              mem_rd   <= 1'b1;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end

          ST_P3: begin
            if (lat_done) begin
              up_size <= size_next;
              ready   <= 1'b1;
              up_wait <= 1'b0;
              state   <= ST_READY;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end

          ST_READY: begin
            if (up_rd) begin
              rd_addr <= up_addr;
              up_wait <= 1'b1;
              if (!in_hdr && !past_end) begin
                state    <= ST_FETCH;
                cnt      <= '0;
                mem_addr <= fetch_addr;
                mem_rd   <= 1'b1;
              end else begin
                state <= ST_HDR;
              end
            end
          end

          // Header bytes and reads past the end of file: answered in one clock
          ST_HDR: begin
            up_din  <= (rd_addr < HDR_LEN) ? hdr_byte : 8'h00;
            up_wait <= 1'b0;
            state   <= ST_READY;
          end

          ST_FETCH: begin
            if (lat_done) begin
              up_din  <= mem_data;
              up_wait <= 1'b0;
              state   <= ST_READY;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vz_upload.sv
// Directed bench for vz_upload with a behavioural RAM and a scoreboard of
// expected file bytes.
module tb_vz_upload;

  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        up_active;
  logic        up_rd;
  logic [15:0] up_addr;
  logic [7:0]  up_din;
  logic        up_wait;
  logic [16:0] up_size;
  logic        ready;
  logic        overrun;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;

  int errors = 0;
  int checks = 0;

  logic [7:0]  ram [0:65535];
  logic [7:0]  pipe [0:MEM_LAT-1];
  int          rd_pulses = 0;
  int          back_to_back = 0;
  logic        mem_rd_q = 1'b0;
  logic [15:0] last_rd_addr = '0;

  logic [7:0]  exp_q [$];
  logic [15:0] m_start;
  logic [16:0] m_size;

  vz_upload #(
    .MEM_LAT   (MEM_LAT),
    .FILE_TYPE (8'hF0),
    .PTR_START (16'h78A4),
    .PTR_END   (16'h78F9)
  ) dut (
    .CLK42MHZ  (clk),
    .RESET     (rst_n),
    .up_active (up_active),
    .up_rd     (up_rd),
    .up_addr   (up_addr),
    .up_din    (up_din),
    .up_wait   (up_wait),
    .up_size   (up_size),
    .ready     (ready),
    .overrun   (overrun),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data)
  );

  always #5 clk = ~clk;

  // RAM with MEM_LAT-clock read pipeline plus mem_rd bookkeeping
  always @(posedge clk) begin
    for (int i = MEM_LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= mem_rd ? ram[mem_addr] : 8'hEE;
    if (mem_rd) begin
      rd_pulses    <= rd_pulses + 1;
      last_rd_addr <= mem_addr;
      if (mem_rd_q) back_to_back <= back_to_back + 1;
    end
    mem_rd_q <= mem_rd;
  end
  assign mem_data = pipe[MEM_LAT-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference byte of the uploaded file at offset a
  function automatic logic [7:0] model_byte(input logic [15:0] a);
    string name = "MISTER";
    logic [31:0] magic = 32'h565A4630;
    if (a < 4) return magic[8*(3-int'(a)) +: 8];
    if (a < 10) return name[int'(a) - 4];
    if (a < 21) return 8'h00;
    if (a == 21) return 8'hF0;
    if (a == 22) return m_start[7:0];
    if (a == 23) return m_start[15:8];
    if ({1'b0, a} < m_size) return ram[16'(m_start + (a - 16'd24))];
    return 8'h00;
  endfunction

  task automatic set_ptrs(input logic [15:0] s, input logic [15:0] e);
    ram[16'h78A4] = s[7:0];
    ram[16'h78A5] = s[15:8];
    ram[16'h78F9] = e[7:0];
    ram[16'h78FA] = e[15:8];
    m_start = s;
    m_size  = (e < s) ? 17'd24 : 17'd24 + {1'b0, 16'(e - s)};
  endtask

  // Raise up_active and time the pointer fetch
  task automatic start_upload(input string tag);
    int n;
    logic wait_ok;
    @(negedge clk); up_active = 1'b1;
    @(negedge clk);
    n = 0;
    wait_ok = 1'b1;
    while (!ready && n < 100) begin
      if (!up_wait) wait_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check({tag, " fetch_clocks"}, n, 12);
    check({tag, " wait_during_fetch"}, wait_ok, 1);
    check({tag, " up_size"}, up_size, m_size);
    check({tag, " wait_after_fetch"}, up_wait, 0);
  endtask

  task automatic stop_upload(input string tag);
    @(negedge clk); up_active = 1'b0;
    @(negedge clk);
    check({tag, " ready_off"}, ready, 0);
    check({tag, " wait_off"}, up_wait, 0);
  endtask

  // One read through the scoreboard: latency and RAM-strobe count checked too
  task automatic do_read(input logic [15:0] a, input int exp_lat, input int exp_pulses);
    int lat;
    int p0;
    string tag;
    tag = $sformatf("rd%0d", a);
    exp_q.push_back(model_byte(a));
    p0 = rd_pulses;
    @(negedge clk); up_rd = 1'b1; up_addr = a;
    @(negedge clk); up_rd = 1'b0;
    lat = 0;
    while (up_wait && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " data"}, up_din, exp_q.pop_front());
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " mem_rd_pulses"}, rd_pulses - p0, exp_pulses);
  endtask

  initial begin
    int p0;
    int n;
    logic [7:0] held;
    for (int i = 0; i < 65536; i++) ram[i] = 8'(i) ^ 8'(i >> 8);
    for (int i = 0; i < MEM_LAT; i++) pipe[i] = 8'h00;
    rst_n = 1'b0; up_active = 1'b0; up_rd = 1'b0; up_addr = '0;
    repeat (2) @(negedge clk);
    check("rst up_din", up_din, 0);
    check("rst up_wait", up_wait, 0);
    check("rst up_size", up_size, 0);
    check("rst ready", ready, 0);
    check("rst overrun", overrun, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_rd", mem_rd, 0);
    rst_n = 1'b1;

    // BASIC program 7AE9..7AF9
    set_ptrs(16'h7AE9, 16'h7AF9);
    ram[16'h7AE9] = 8'hA5;
    start_upload("up1");
    check("up1 size40", up_size, 17'd40);
    for (int a = 0; a < 4; a++) do_read(16'(a), 1, 0);
    do_read(16'd4, 1, 0);
    do_read(16'd12, 1, 0);
    for (int a = 21; a < 24; a++) do_read(16'(a), 1, 0);
    do_read(16'd24, 3, 1);
    check("rd24 mem_addr", last_rd_addr, 16'h7AE9);
    check("rd24 value", up_din, 8'hA5);
    do_read(16'd39, 3, 1);
    do_read(16'd40, 1, 0);

    // Second strobe while a RAM read is outstanding is dropped
    exp_q.push_back(model_byte(16'd25));
    p0 = rd_pulses;
    @(negedge clk); up_rd = 1'b1; up_addr = 16'd25;
    @(negedge clk); up_addr = 16'd30;
    @(negedge clk); up_rd = 1'b0;
    n = 0;
    while (up_wait && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ovr flag", overrun, 1);
    check("ovr data", up_din, exp_q.pop_front());
    check("ovr pulses", rd_pulses - p0, 1);
    check("ovr state_ok", up_wait, 0);
    stop_upload("up1");
    check("ovr sticky_idle", overrun, 1);

    // end < start gives an empty program
    set_ptrs(16'hFFF0, 16'h0008);
    start_upload("up2");
    check("up2 overrun_cleared", overrun, 0);
    check("up2 size24", up_size, 17'd24);
    do_read(16'd24, 1, 0);
    stop_upload("up2");

    // start FFF0, end FFF8: offsets 32.. are past the end
    set_ptrs(16'hFFF0, 16'hFFF8);
    ram[16'hFFF0] = 8'h3C;
    ram[16'hFFF7] = 8'h81;
    start_upload("up3");
    check("up3 size32", up_size, 17'd32);
    do_read(16'd31, 3, 1);
    do_read(16'd39, 1, 0);

    // Abort during a RAM fetch: late data must not reach up_din
    held = up_din;
    @(negedge clk); up_rd = 1'b1; up_addr = 16'd24;
    @(negedge clk); up_rd = 1'b0; up_active = 1'b0;
    @(negedge clk);
    check("abort ready", ready, 0);
    check("abort wait", up_wait, 0);
    check("abort din_now", up_din, held);
    repeat (4) @(negedge clk);
    check("abort din_late", up_din, held);
    check("mem_rd never back_to_back", back_to_back, 0);

    // Asynchronous reset in the middle of P2
    @(negedge clk); up_active = 1'b1;
    repeat (7) @(negedge clk);
    check("p2 mem_addr", mem_addr, 16'h78F9);
    #2 rst_n = 1'b0;
    #1;
    check("arst up_din", up_din, 0);
    check("arst up_wait", up_wait, 0);
    check("arst up_size", up_size, 0);
    check("arst ready", ready, 0);
    check("arst overrun", overrun, 0);
    check("arst mem_addr", mem_addr, 0);
    check("arst mem_rd", mem_rd, 0);
    up_active = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
